// File: rtl/systolic_pkg.sv
// systolic_pkg: shared constants and controller state encoding for the systolic array.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package systolic_pkg;

  localparam int              DATA_W    = 16;
  localparam int              FRAC_BITS = 10;
  localparam logic [15:0]     ONE       = 16'h0400;  // 1.0 in Q5.10

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    COMPUTE = 3'd2,
    DRAIN   = 3'd3,
    FIN     = 3'd4
  } state_t;

endpackage

// File: rtl/systolic_idx_cnt.sv
// systolic_idx_cnt: row-major row/col counter over an N x N grid, with last-position flag.
// Latency: row/col update on the clock after en; last is combinational from row/col.
// Backpressure: counter holds whenever en is low, so the selected position is stable.
// Ports: clk, rst (async active-low), en (advance one position), clr (return to 0,0),
//        row/col (current position), last (position N*N-1).
module systolic_idx_cnt
  import systolic_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  output logic [IW-1:0] row,
  output logic [IW-1:0] col,
  output logic          last
);

  logic col_end;

  assign col_end = (col == IW'(N - 1));
  assign last    = col_end && (row == IW'(N - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (en) begin
      if (last) begin
        // Wrap explicitly so non-power-of-two N never lands on an unused code.
        row <= '0;
        col <= '0;
      end else if (col_end) begin
        row <= row + IW'(1);
        col <= '0;
      end else begin
        col <= col + IW'(1);
      end
    end
  end

endmodule

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: sequencer for an N x N output-stationary PE array: clear, K+N-1 compute steps, drain N*N results.
// Latency: start -> CLEAR next cycle; compute K+N-1 enabled cycles; one beat per accepted handshake; done 1 cycle after last beat.
// Backpressure: stall freezes compute (t and enables hold); out_ready low holds the current beat and sel_row/sel_col.
// Ports: clk, rst (async active-low); start/k_len job request; stall operand hold;
//        busy/done status; arr_clr_n/sys_pe_en array control; feed_t/a_row_vld/b_vld feeder control;
//        sel_row/sel_col/out_valid/out_last/out_ready result stream.
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int KW = 8,
  localparam int TW = KW + 1,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [KW-1:0] k_len,
  input  logic          stall,
  output logic          busy,
  output logic          done,
  output logic          arr_clr_n,
  output logic          sys_pe_en,
  output logic [TW-1:0] feed_t,
  output logic [N-1:0]  a_row_vld,
  output logic          b_vld,
  output logic [IW-1:0] sel_row,
  output logic [IW-1:0] sel_col,
  output logic          out_valid,
  output logic          out_last,
  input  logic          out_ready
);

  state_t        state, state_nxt;
  logic [KW-1:0] k_reg;
  logic [TW-1:0] t, t_nxt;
  logic [TW-1:0] k_ext;
  logic          t_last;
  logic          beat_acc;
  logic          idx_last;

  // Full TW-width compares: K+N-2 always fits, so no wrap is possible.
  assign k_ext  = {1'b0, k_reg};
  assign t_last = (t == k_ext + TW'(N - 2));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      k_reg     <= '0;
      t         <= '0;
      arr_clr_n <= 1'b1;
    end else begin
      state     <= state_nxt;
      t         <= t_nxt;
      // Registered so the array reset is glitch-free; low exactly during CLEAR.
      arr_clr_n <= (state_nxt != CLEAR);
      if (state == IDLE && start) begin
        k_reg <= k_len;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    t_nxt     = t;
    busy      = 1'b1;
    done      = 1'b0;
    sys_pe_en = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = CLEAR;
      end
      CLEAR: begin
        t_nxt     = '0;
        state_nxt = (k_reg == '0) ? DRAIN : COMPUTE;
      end
      COMPUTE: begin
        sys_pe_en = !stall;
        if (!stall) begin
          if (t_last) begin
            t_nxt     = '0;
            state_nxt = DRAIN;
          end else begin
            t_nxt = t + TW'(1);
          end
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready && idx_last) state_nxt = FIN;
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Row i sees B[t-i] after i shift stages, so its A operand is skewed by i steps.
  always_comb begin
    a_row_vld = '0;
    b_vld     = 1'b0;
    if (state == COMPUTE) begin
      b_vld = (t < k_ext);
      for (int i = 0; i < N; i++) begin
        a_row_vld[i] = (t >= TW'(i)) && (t < k_ext + TW'(i));
      end
    end
  end

  assign feed_t   = t;
  assign beat_acc = out_valid && out_ready;
  assign out_last = out_valid && idx_last;

  systolic_idx_cnt #(.N(N)) u_idx (
    .clk  (clk),
    .rst  (rst),
    .en   (beat_acc),
    .clr  (done),
    .row  (sel_row),
    .col  (sel_col),
    .last (idx_last)
  );

endmodule

// File: tb/tb_systolic_ctrl.sv
// tb_systolic_ctrl: controller + behavioural 4x4 PE array, feeder and result mux, scoreboarded against a matrix-product model.
// Latency: n/a (testbench).
// Backpressure: out_ready and stall are driven by the stimulus process.
`timescale 1ns/1ps
module tb_systolic_ctrl;
  import systolic_pkg::*;

  localparam int N    = 4;
  localparam int KW   = 8;
  localparam int TW   = KW + 1;
  localparam int IW   = $clog2(N);
  localparam int KMAX = 16;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic              last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst, start, stall, out_ready;
  logic [KW-1:0] k_len;
  logic          busy, done, arr_clr_n, sys_pe_en, b_vld, out_valid, out_last;
  logic [TW-1:0] feed_t;
  logic [N-1:0]  a_row_vld;
  logic [IW-1:0] sel_row, sel_col;

  systolic_ctrl #(.N(N), .KW(KW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .k_len     (k_len),
    .stall     (stall),
    .busy      (busy),
    .done      (done),
    .arr_clr_n (arr_clr_n),
    .sys_pe_en (sys_pe_en),
    .feed_t    (feed_t),
    .a_row_vld (a_row_vld),
    .b_vld     (b_vld),
    .sel_row   (sel_row),
    .sel_col   (sel_col),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  beat_t exp_q[$];
  int cur_k = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Operand matrices and feeder
  logic signed [DATA_W-1:0] A_m [N][KMAX];
  logic signed [DATA_W-1:0] B_m [KMAX][N];
  logic [DATA_W-1:0] a_in  [N];
  logic [DATA_W-1:0] b_top [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_in[i]  = '0;
      b_top[i] = '0;
      if (a_row_vld[i]) a_in[i] = A_m[i][int'(feed_t) - i];
      if (b_vld) b_top[i] = B_m[int'(feed_t)][i];
    end
  end

  // Behavioural PE array: A broadcast per row, B shifted down one row per enabled step
  logic [DATA_W-1:0] acc  [N][N];
  logic [DATA_W-1:0] bq   [N][N];
  logic [DATA_W-1:0] bsrc [N][N];
  wire arr_rst_n = rst & arr_clr_n;

  function automatic logic [DATA_W-1:0] qmul(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic signed [2*DATA_W-1:0] p;
    p = $signed(a) * $signed(b);
    return p[FRAC_BITS+DATA_W-1:FRAC_BITS];
  endfunction

  always_comb begin
    for (int j = 0; j < N; j++) begin
      bsrc[0][j] = b_top[j];
      for (int i = 1; i < N; i++) bsrc[i][j] = bq[i-1][j];
    end
  end

  always @(posedge clk or negedge arr_rst_n) begin
    if (!arr_rst_n) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          acc[i][j] <= '0;
          bq[i][j]  <= '0;
        end
    end else if (sys_pe_en) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          acc[i][j] <= acc[i][j] + qmul(a_in[i], bsrc[i][j]);
          bq[i][j]  <= bsrc[i][j];
        end
    end
  end

  wire [DATA_W-1:0] res = acc[sel_row][sel_col];

  // Monitor: compares beats against the scoreboard and tracks control behaviour
  int            exp_t = 0, en_cnt = 0, clr_len = 0;
  bit            hold = 0, done_pend = 0;
  logic [IW-1:0] prev_row, prev_col;

  always @(negedge clk) begin
    if (!rst) begin
      hold      = 0;
      done_pend = 0;
    end else begin
      logic [N-1:0] exp_av;
      beat_t        e;
      if (!arr_clr_n) begin
        exp_t  = 0;
        en_cnt = 0;
        clr_len++;
      end else if (clr_len != 0) begin
        check("clr_len", clr_len, 1);
        clr_len = 0;
      end
      if (stall && busy) check("en_in_stall", sys_pe_en, 0);
      if (sys_pe_en) begin
        check("feed_t", feed_t, exp_t);
        for (int i = 0; i < N; i++) exp_av[i] = (exp_t >= i) && (exp_t < cur_k + i);
        check("a_row_vld", a_row_vld, exp_av);
        check("b_vld", b_vld, exp_t < cur_k);
        exp_t++;
        en_cnt++;
      end
      if (done || done_pend) begin
        check("done", done, done_pend);
        if (done_pend) check("en_cycles", en_cnt, (cur_k == 0) ? 0 : cur_k + N - 1);
        done_pend = 0;
      end
      if (out_valid) begin
        check("vld_in_drain", {a_row_vld, b_vld, sys_pe_en}, 0);
        if (hold) check("sel_stable", {sel_row, sel_col}, {prev_row, prev_col});
        if (out_ready) begin
          check("beat_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("beat_data", res, e.d);
            check("beat_last", out_last, e.last);
            if (e.last) done_pend = 1;
          end
        end
        hold     = !out_ready;
        prev_row = sel_row;
        prev_col = sel_col;
      end else begin
        hold = 0;
      end
    end
  end

  // Stimulus helpers
  task automatic check_reset_vals();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_clr_n", arr_clr_n, 1);
    check("rst_pe_en", sys_pe_en, 0);
    check("rst_feed_t", feed_t, 0);
    check("rst_a_vld", a_row_vld, 0);
    check("rst_b_vld", b_vld, 0);
    check("rst_sel", {sel_row, sel_col}, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
  endtask

  task automatic set_ops(input int amode, input int bmode);
    for (int i = 0; i < N; i++)
      for (int k = 0; k < KMAX; k++) begin
        case (amode)
          0: A_m[i][k] = (i == k) ? ONE : '0;
          1: A_m[i][k] = ONE;
          2: A_m[i][k] = '0;
          default: A_m[i][k] = DATA_W'($urandom);
        endcase
        case (bmode)
          0: B_m[k][i] = DATA_W'(ONE * (4 * k + i));
          1: B_m[k][i] = ONE;
          default: B_m[k][i] = DATA_W'($urandom);
        endcase
      end
  endtask

  task automatic start_job(input int kk);
    beat_t b;
    longint s;
    check("idle_before_start", busy, 0);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int k = 0; k < kk; k++) s += (longint'(A_m[i][k]) * longint'(B_m[k][j])) >>> FRAC_BITS;
        b.d    = s[DATA_W-1:0];
        b.last = (i == N - 1) && (j == N - 1);
        exp_q.push_back(b);
      end
    cur_k = kk;
    @(posedge clk); #1;
    start = 1'b1;
    k_len = KW'(kk);
    @(posedge clk); #1;
    start = 1'b0;
    k_len = KW'($urandom);
  endtask

  task automatic finish_job(input int stall_mode, input int rdy_pct, input bit inj_start);
    bit seen_done = 0;
    bit injected  = 0;
    int cyc = 0;
    while (!seen_done && cyc < 3000) begin
      @(posedge clk); #1;
      case (stall_mode)
        1: stall = ~stall;
        2: stall = 1'($urandom_range(0, 1));
        default: stall = 1'b0;
      endcase
      out_ready = ($urandom_range(0, 99) < rdy_pct);
      start = 1'b0;
      if (inj_start && !injected && out_valid) begin
        start    = 1'b1;
        k_len    = 8'd7;
        injected = 1;
      end
      cyc++;
      @(negedge clk);
      if (done) seen_done = 1;
    end
    check("job_done_seen", seen_done, 1);
    check("beats_left", exp_q.size(), 0);
    stall     = 1'b0;
    out_ready = 1'b0;
    start     = 1'b0;
    @(negedge clk);
    check("idle_after_done", busy, 0);
  endtask

  initial begin
    bit got;
    rst = 1'b1; start = 1'b0; stall = 1'b0; out_ready = 1'b0; k_len = '0;
    set_ops(0, 0);
    #3 rst = 1'b0;
    #20 check_reset_vals();
    @(posedge clk); #1 rst = 1'b1;

    // 1: identity A, ramp B, full-speed sink
    start_job(4);
    finish_job(0, 100, 0);
    // 2: stall toggling every cycle
    start_job(4);
    finish_job(1, 100, 0);
    // 3: sparse out_ready
    start_job(4);
    finish_job(0, 30, 0);
    // 4: K = 0
    set_ops(3, 3);
    start_job(0);
    finish_job(0, 100, 0);
    // 5: reset in the middle of COMPUTE, then rerun
    set_ops(0, 0);
    start_job(4);
    got = 0;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk);
      if (sys_pe_en && feed_t == TW'(3)) got = 1;
    end
    check("reach_t3", got, 1);
    #1 rst = 1'b0;
    #1 check_reset_vals();
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b1;
    start_job(4);
    finish_job(0, 100, 0);
    // 6: start during DRAIN ignored; follow-up job with A=0 must not see stale sums
    set_ops(1, 1);
    start_job(4);
    finish_job(0, 50, 1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("no_queued_job", busy, 0);
    end
    set_ops(2, 1);
    start_job(4);
    finish_job(0, 100, 0);
    // Randomized jobs
    for (int r = 0; r < 6; r++) begin
      set_ops(3, 3);
      start_job($urandom_range(1, 12));
      finish_job(2, 60, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
